// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter
//   Shares the read/write port (port 0) of one OpenRAM SRAM macro between two
//   requesters using round-robin arbitration. After reset it can zero-fill the
//   whole array before it accepts any request. Reads return one cycle after
//   the grant, and the data comes straight from the macro's dout0.
//
// Ports
//   wb_clk_i, wb_rst_i      : clock (also the macro clock), synchronous active-high reset
//   rN_req/rN_ready         : request valid / accepted this cycle (N = 0, 1)
//   rN_we/rN_wmask          : write select and byte enables
//   rN_addr/rN_wdata        : word address and write data
//   rN_rvalid/rN_rdata      : read response, valid one cycle after a read grant
//   init_done               : high once the zero-fill has completed
//   sram_csb0/sram_web0     : macro chip select / write enable, both active-low
//   sram_wmask0/addr0/din0  : macro byte mask, address and write data
//   sram_dout0              : macro read data
module sram_rw_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  r0_req,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [NUM_WMASKS-1:0] r0_wmask,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [NUM_WMASKS-1:0] r1_wmask,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam state_e                RESET_STATE = INIT_EN ? ST_INIT : ST_SERVE;
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST   = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_r;
    state_e                state_next_s;
    logic [ADDR_WIDTH-1:0] init_cnt_r;
    logic                  last_grant_r;
    logic                  init_done_r;
    logic                  rvalid0_r;
    logic                  rvalid1_r;

    // Last values driven to the macro; replayed on idle cycles so the
    // macro pins only move when an access is actually issued.
    logic                  web_hold_r;
    logic [NUM_WMASKS-1:0] wmask_hold_r;
    logic [ADDR_WIDTH-1:0] addr_hold_r;
    logic [DATA_WIDTH-1:0] din_hold_r;

    logic                  grant0_s;
    logic                  grant1_s;
    logic                  csb_s;
    logic                  web_s;
    logic [NUM_WMASKS-1:0] wmask_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] din_s;

    // Next-state, same-cycle arbitration and macro pin drive
    always_comb begin
        state_next_s = state_r;
        grant0_s     = 1'b0;
        grant1_s     = 1'b0;
        csb_s        = 1'b1;
        web_s        = web_hold_r;
        wmask_s      = wmask_hold_r;
        addr_s       = addr_hold_r;
        din_s        = din_hold_r;
        if (wb_rst_i) begin
            // Macro is deselected and no requester is accepted during reset.
            web_s = 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    csb_s   = 1'b0;
                    web_s   = 1'b0;
                    wmask_s = {NUM_WMASKS{1'b1}};
                    addr_s  = init_cnt_r;
                    din_s   = {DATA_WIDTH{1'b0}};
                    if (init_cnt_r == INIT_LAST) begin
                        state_next_s = ST_SERVE;
                    end else begin
                        state_next_s = ST_INIT;
                    end
                end
                ST_SERVE: begin
                    // With both requesting, the one not served last wins.
                    grant0_s = r0_req & (~r1_req | last_grant_r);
                    grant1_s = r1_req & (~r0_req | ~last_grant_r);
                    if (grant0_s) begin
                        csb_s   = 1'b0;
                        web_s   = ~r0_we;
                        wmask_s = r0_wmask;
                        addr_s  = r0_addr;
                        din_s   = r0_wdata;
                    end else if (grant1_s) begin
                        csb_s   = 1'b0;
                        web_s   = ~r1_we;
                        wmask_s = r1_wmask;
                        addr_s  = r1_addr;
                        din_s   = r1_wdata;
                    end else begin
                        csb_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_INIT;
                end
            endcase
        end
    end

    // State, init counter, round-robin pointer, read-valid pipeline, pin hold
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r      <= RESET_STATE;
            init_cnt_r   <= {ADDR_WIDTH{1'b0}};
            last_grant_r <= 1'b1;
            init_done_r  <= ~INIT_EN;
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
            web_hold_r   <= 1'b1;
            wmask_hold_r <= {NUM_WMASKS{1'b0}};
            addr_hold_r  <= {ADDR_WIDTH{1'b0}};
            din_hold_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + CNT_ONE;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
            if ((state_r == ST_INIT) && (state_next_s == ST_SERVE)) begin
                init_done_r <= 1'b1;
            end else begin
                init_done_r <= init_done_r;
            end
            if (grant0_s | grant1_s) begin
                last_grant_r <= grant1_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            // The macro presents read data in the cycle after the access.
            rvalid0_r    <= grant0_s & ~r0_we;
            rvalid1_r    <= grant1_s & ~r1_we;
            web_hold_r   <= web_s;
            wmask_hold_r <= wmask_s;
            addr_hold_r  <= addr_s;
            din_hold_r   <= din_s;
        end
    end

    assign r0_ready    = grant0_s;
    assign r1_ready    = grant1_s;
    // Gating with reset drops a response that would land in the reset cycle.
    assign r0_rvalid   = rvalid0_r & ~wb_rst_i;
    assign r1_rvalid   = rvalid1_r & ~wb_rst_i;
    assign r0_rdata    = sram_dout0;
    assign r1_rdata    = sram_dout0;
    assign init_done   = init_done_r & ~wb_rst_i;
    assign sram_csb0   = csb_s;
    assign sram_web0   = web_s;
    assign sram_wmask0 = wmask_s;
    assign sram_addr0  = addr_s;
    assign sram_din0   = din_s;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Testbench for sram_rw_arbiter: a behavioural SRAM macro plus a reference
// memory/arbitration model; directed steps followed by a random phase.
module tb_sram_rw_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r0_req, r0_ready, r0_we, r0_rvalid;
    logic [3:0]  r0_wmask;
    logic [7:0]  r0_addr;
    logic [31:0] r0_wdata, r0_rdata;
    logic        r1_req, r1_ready, r1_we, r1_rvalid;
    logic [3:0]  r1_wmask;
    logic [7:0]  r1_addr;
    logic [31:0] r1_wdata, r1_rdata;
    logic        init_done, sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    sram_rw_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4), .INIT_EN(1'b1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .r0_req(r0_req), .r0_ready(r0_ready), .r0_we(r0_we), .r0_wmask(r0_wmask),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_ready(r1_ready), .r1_we(r1_we), .r1_wmask(r1_wmask),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_dout0(sram_dout0)
    );

    // Second instance without the zero-fill
    logic        b_rst, b_r0_req, b_r0_ready, b_r0_rvalid;
    logic        b_r1_req, b_r1_ready, b_r1_rvalid;
    logic [31:0] b_r0_rdata, b_r1_rdata, b_din0;
    logic        b_init_done, b_csb0, b_web0;
    logic [3:0]  b_wmask0;
    logic [7:0]  b_addr0;

    sram_rw_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4), .INIT_EN(1'b0)) dut_noinit (
        .wb_clk_i(clk), .wb_rst_i(b_rst),
        .r0_req(b_r0_req), .r0_ready(b_r0_ready), .r0_we(1'b0), .r0_wmask(4'h0),
        .r0_addr(8'h33), .r0_wdata(32'h0), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_ready(b_r1_ready), .r1_we(1'b0), .r1_wmask(4'h0),
        .r1_addr(8'h44), .r1_wdata(32'h0), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
        .init_done(b_init_done), .sram_csb0(b_csb0), .sram_web0(b_web0),
        .sram_wmask0(b_wmask0), .sram_addr0(b_addr0), .sram_din0(b_din0),
        .sram_dout0(32'hCAFE_F00D)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural macro: inputs registered at posedge, read data after negedge
    logic [31:0] mem [256];
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_addr = 8'h0;
    always @(posedge clk) begin
        rd_pend <= 1'b0;
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= merge(mem[sram_addr0], sram_din0, sram_wmask0);
            else begin
                rd_pend <= 1'b1;
                rd_addr <= sram_addr0;
            end
        end
    end
    always @(negedge clk) sram_dout0 <= rd_pend ? mem[rd_addr] : $urandom;

    // Reference model
    logic [31:0] ref_mem [256];
    bit          pv [2];
    bit          pwe [2];
    logic [3:0]  pm [2];
    logic [7:0]  pa [2];
    logic [31:0] pd [2];
    bit          prev_g;
    bit          erv [2];
    logic [31:0] erd [2];
    logic [31:0] got_rd [2];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int k, input bit we, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        pv[k] = 1'b1; pwe[k] = we; pa[k] = a; pd[k] = d; pm[k] = m;
    endtask

    task automatic drive();
        r0_req = pv[0]; r0_we = pwe[0]; r0_addr = pa[0]; r0_wdata = pd[0]; r0_wmask = pm[0];
        r1_req = pv[1]; r1_we = pwe[1]; r1_addr = pa[1]; r1_wdata = pd[1]; r1_wmask = pm[1];
    endtask

    task automatic do_reset(input int n);
        drive();
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk); #1;
            chk("rst_r0_ready", r0_ready, 1'b0);
            chk("rst_r1_ready", r1_ready, 1'b0);
            chk("rst_r0_rvalid", r0_rvalid, 1'b0);
            chk("rst_r1_rvalid", r1_rvalid, 1'b0);
            chk("rst_init_done", init_done, 1'b0);
            chk("rst_csb0", sram_csb0, 1'b1);
            chk("rst_web0", sram_web0, 1'b1);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        erv[0] = 1'b0; erv[1] = 1'b0;
        prev_g = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    endtask

    task automatic run_init();
        drive();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); #1;
            chk("init_r0_ready", r0_ready, 1'b0);
            chk("init_r1_ready", r1_ready, 1'b0);
            chk("init_done_low", init_done, 1'b0);
            chk("init_csb0", sram_csb0, 1'b0);
            chk("init_web0", sram_web0, 1'b0);
            chk("init_din0", sram_din0, 32'h0);
            chk("init_wmask0", sram_wmask0, 4'hF);
            chk("init_addr0", sram_addr0, 32'(i));
            chk("init_r0_rvalid", r0_rvalid, 1'b0);
            chk("init_r1_rvalid", r1_rvalid, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic serve_cycle();
        bit g0, g1;
        int k;
        drive();
        @(negedge clk); #1;
        g0 = pv[0] && (!pv[1] || prev_g == 1'b1);
        g1 = pv[1] && !g0;
        chk("init_done", init_done, 1'b1);
        chk("r0_ready", r0_ready, g0);
        chk("r1_ready", r1_ready, g1);
        chk("csb0", sram_csb0, !(g0 || g1));
        chk("r0_rvalid", r0_rvalid, erv[0]);
        chk("r1_rvalid", r1_rvalid, erv[1]);
        if (erv[0]) begin chk("r0_rdata", r0_rdata, erd[0]); got_rd[0] = r0_rdata; end
        if (erv[1]) begin chk("r1_rdata", r1_rdata, erd[1]); got_rd[1] = r1_rdata; end
        erv[0] = 1'b0; erv[1] = 1'b0;
        if (g0 || g1) begin
            k = g1 ? 1 : 0;
            chk("web0", sram_web0, !pwe[k]);
            chk("addr0", sram_addr0, pa[k]);
            if (pwe[k]) begin
                chk("din0", sram_din0, pd[k]);
                chk("wmask0", sram_wmask0, pm[k]);
                ref_mem[pa[k]] = merge(ref_mem[pa[k]], pd[k], pm[k]);
            end else begin
                erv[k] = 1'b1;
                erd[k] = ref_mem[pa[k]];
            end
            prev_g = g1;
            pv[k] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0;
        got_rd[0] = 32'hFFFF_FFFF; got_rd[1] = 32'hFFFF_FFFF;
        req(1, 1'b0, 8'h0, 32'h0, 4'h0); pv[1] = 1'b0;
        b_rst = 1'b1; b_r0_req = 1'b1; b_r1_req = 1'b0;

        // Zero-fill with r0 already requesting a read of 0x10
        req(0, 1'b0, 8'h10, 32'h0, 4'h0);
        do_reset(2);
        run_init();
        serve_cycle();
        serve_cycle();
        chk("rd_0x10_zero", got_rd[0], 32'h0000_0000);

        // Masked write then read back
        req(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'b0101);
        serve_cycle();
        req(0, 1'b0, 8'h10, 32'h0, 4'h0);
        serve_cycle();
        serve_cycle();
        chk("rd_masked", got_rd[0], 32'h00AD_00EF);

        // Both requesters reading continuously
        req(0, 1'b1, 8'h01, 32'h1111_1111, 4'hF); serve_cycle();
        req(1, 1'b1, 8'h02, 32'h2222_2222, 4'hF); serve_cycle();
        for (int i = 0; i < 4; i++) begin
            if (!pv[0]) req(0, 1'b0, 8'h01, 32'h0, 4'h0);
            if (!pv[1]) req(1, 1'b0, 8'h02, 32'h0, 4'h0);
            serve_cycle();
        end
        repeat (3) serve_cycle();
        chk("alt_rd_r0", got_rd[0], 32'h1111_1111);
        chk("alt_rd_r1", got_rd[1], 32'h2222_2222);

        // Back-to-back write then read on r1
        req(1, 1'b1, 8'h20, 32'h1234_5678, 4'hF); serve_cycle();
        req(1, 1'b0, 8'h20, 32'h0, 4'h0); serve_cycle();
        serve_cycle();
        chk("b2b_rd", got_rd[1], 32'h1234_5678);

        // Random traffic on a small address window
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && $urandom_range(0, 3) != 0)
                    req(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                        4'($urandom_range(0, 15)));
            end
            serve_cycle();
        end
        repeat (3) serve_cycle();

        // Reset the cycle after a read grant; re-init clears 0x20
        req(1, 1'b1, 8'h20, 32'h1234_5678, 4'hF); serve_cycle();
        req(0, 1'b0, 8'h20, 32'h0, 4'h0); serve_cycle();
        do_reset(1);
        run_init();
        req(0, 1'b0, 8'h20, 32'h0, 4'h0);
        serve_cycle();
        serve_cycle();
        chk("rd_after_reinit", got_rd[0], 32'h0000_0000);

        // Instance without zero-fill: ready as soon as reset drops
        @(negedge clk); #1;
        chk("noinit_rst_done", b_init_done, 1'b0);
        chk("noinit_rst_ready", b_r0_ready, 1'b0);
        chk("noinit_rst_csb0", b_csb0, 1'b1);
        @(posedge clk); #1;
        b_rst = 1'b0;
        @(negedge clk); #1;
        chk("noinit_done", b_init_done, 1'b1);
        chk("noinit_ready", b_r0_ready, 1'b1);
        chk("noinit_csb0", b_csb0, 1'b0);
        chk("noinit_web0", b_web0, 1'b1);
        chk("noinit_addr0", b_addr0, 8'h33);
        @(posedge clk); #1;
        b_r0_req = 1'b0;
        @(negedge clk); #1;
        chk("noinit_rvalid", b_r0_rvalid, 1'b1);
        chk("noinit_rdata", b_r0_rdata, 32'hCAFE_F00D);
        chk("noinit_r1_rvalid", b_r1_rvalid, 1'b0);
        chk("noinit_idle_csb0", b_csb0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
